// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU/immediate/writeback encodings and FSM states shared by the multi-cycle controller
package ctrl_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_COPY_B = 4'b1010
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {WB_MEM, WB_ALU, WB_PC4} wb_sel_t;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  function automatic logic opc_legal(input logic [6:0] opc, input logic has_jump);
    return (opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP_IMM, OPC_OP}) ||
           (has_jump && (opc inside {OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC}));
  endfunction
endpackage

// File: rtl/multicycle_controller_aludecode.sv
// aludecode: maps opcode/funct3/funct7[5] to the ALU operation; LUI passes the immediate through
module aludecode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_op_t    alu_op
);
  alu_op_t f3_op;
  logic    arith;
  always_comb begin
    arith = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
    case (funct3)
      3'b000:  f3_op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
    alu_op = (opcode == OPC_LUI) ? ALU_COPY_B : arith ? f3_op : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I with IR,
// variable-latency memory handshakes, bus timeout and a retire counter
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter bit          HAS_JUMP    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_inst,
  input  logic             i_inst_vld,
  input  logic             i_dmem_ready,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic [31:0]      o_ir,
  output logic             o_imem_req,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [3:0]       o_alu_op,
  output logic             o_alu_a_sel,
  output logic             o_alu_b_sel,
  output logic [2:0]       o_imm_sel,
  output logic             o_br_un,
  output logic             o_reg_wen,
  output logic [1:0]       o_wb_sel,
  output logic             o_pc_we,
  output logic             o_pc_sel,
  output logic             o_insn_vld,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instret
);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  state_t        state, state_nxt;
  logic [31:0]   ir;
  logic [TW-1:0] tmo_cnt;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic          is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_jump, is_mem;
  logic          legal, taken, waiting, tmo_hit;
  alu_op_t       alu_op;
  assign opc       = ir[6:0];
  assign f3        = ir[14:12];
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;
  assign is_branch = opc == OPC_BRANCH;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_jump   = is_jal | is_jalr;
  assign is_mem    = is_load | is_store;
  assign legal     = opc_legal(opc, HAS_JUMP);
  // funct3[2] picks less vs equal, funct3[0] inverts (BNE/BGE/BGEU)
  assign taken     = (f3[2] ? i_br_less : i_br_equal) ^ f3[0];
  // reset gating keeps the timeout from firing while the core is held in reset
  assign waiting   = i_reset && ((state == S_FETCH && !i_inst_vld) || (state == S_MEM && !i_dmem_ready));
  assign tmo_hit   = waiting && tmo_cnt == TW'(MEM_TIMEOUT - 1);
  aludecode u_aludecode (
    .opcode   (opc),
    .funct3   (f3),
    .funct7_b5(ir[30]),
    .alu_op   (alu_op)
  );
  assign o_ir        = ir;
  assign o_alu_op    = alu_op;
  assign o_alu_a_sel = is_branch | is_jal | is_auipc;
  assign o_alu_b_sel = opc != OPC_OP;
  assign o_imm_sel   = is_store ? IMM_S : is_branch ? IMM_B : (is_lui | is_auipc) ? IMM_U : is_jal ? IMM_J : IMM_I;
  assign o_br_un     = is_branch & f3[2] & f3[1];
  assign o_wb_sel    = is_load ? WB_MEM : is_jump ? WB_PC4 : WB_ALU;
  always_comb begin
    state_nxt  = state;
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_reg_wen  = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    o_insn_vld = 1'b0;
    o_illegal  = 1'b0;
    o_bus_err  = 1'b0;
    case (state)
      S_FETCH: begin
        o_imem_req = i_reset;
        o_bus_err  = tmo_hit;
        state_nxt  = i_inst_vld ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        o_illegal = !legal;
        o_pc_we   = !legal;
        state_nxt = legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        o_pc_we    = is_branch | is_jump;
        o_pc_sel   = is_branch ? taken : is_jump;
        o_insn_vld = is_branch;
        state_nxt  = is_branch ? S_FETCH : is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_store;
        o_bus_err  = tmo_hit;
        o_pc_we    = is_store & i_dmem_ready;
        o_insn_vld = is_store & i_dmem_ready;
        state_nxt  = i_dmem_ready ? (is_store ? S_FETCH : S_WB) : tmo_hit ? S_FETCH : S_MEM;
      end
      S_WB: begin
        o_reg_wen  = 1'b1;
        o_pc_we    = !is_jump;
        o_insn_vld = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_FETCH;
      ir        <= NOP;
      tmo_cnt   <= '0;
      o_instret <= '0;
    end else begin
      state     <= state_nxt;
      if (state == S_FETCH && i_inst_vld) ir <= i_inst;
      tmo_cnt   <= (waiting && !tmo_hit) ? tmo_cnt + TW'(1) : '0;
      o_instret <= o_instret + CNT_W'(o_insn_vld);
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream with memory latency responders,
// checked against a per-instruction behavioural model of cycle counts and strobe totals
module tb_multicycle_controller;
  import ctrl_pkg::*;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6,
                 C_LUI = 7, C_AUIPC = 8, C_ILL = 9, C_FTO = 10;
  typedef struct {
    int cyc, n_imem, n_dmem, n_we, n_wen, n_pcwe, pc_sel, n_ret, n_ill, n_berr, wb, alu, a, b, imm, bun;
  } obs_t;
  logic          i_clk = 1'b0;
  logic          i_reset, i_inst_vld, i_dmem_ready, i_br_less, i_br_equal;
  logic [31:0]   i_inst;
  logic [31:0]   o_ir;
  logic          o_imem_req, o_dmem_req, o_dmem_we, o_alu_a_sel, o_alu_b_sel, o_br_un;
  logic [3:0]    o_alu_op;
  logic [2:0]    o_imm_sel;
  logic          o_reg_wen, o_pc_we, o_pc_sel, o_insn_vld, o_illegal, o_bus_err;
  logic [1:0]    o_wb_sel;
  logic [CW-1:0] o_instret;
  int            n_checks = 0, n_errs = 0, exp_ret = 0;
  logic [31:0]   last_ir = 32'h13;
  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW), .HAS_JUMP(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_inst_vld(i_inst_vld),
    .i_dmem_ready(i_dmem_ready), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
    .o_ir(o_ir), .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_alu_op(o_alu_op), .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_imm_sel(o_imm_sel),
    .o_br_un(o_br_un), .o_reg_wen(o_reg_wen), .o_wb_sel(o_wb_sel), .o_pc_we(o_pc_we),
    .o_pc_sel(o_pc_sel), .o_insn_vld(o_insn_vld), .o_illegal(o_illegal), .o_bus_err(o_bus_err),
    .o_instret(o_instret)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] build(input int cls);
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  ill_opc [5] = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011, 7'b0101111};
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r  = $urandom;
    f3 = r[14:12];
    case (cls)
      C_R: begin
        r[6:0]   = OPC_OP;
        r[31:25] = {1'b0, (f3 == 3'd0 || f3 == 3'd5) & r[30], 5'b0};
      end
      C_I: begin
        r[6:0] = OPC_OP_IMM;
        if (f3 == 3'd1) r[31:25] = 7'b0;
        if (f3 == 3'd5) r[31:25] = {1'b0, r[30], 5'b0};
      end
      C_LD:    r[6:0] = OPC_LOAD;
      C_ST:    r[6:0] = OPC_STORE;
      C_BR:    begin r[6:0] = OPC_BRANCH; r[14:12] = br_f3[$urandom_range(0, 5)]; end
      C_JAL:   r[6:0] = OPC_JAL;
      C_JALR:  begin r[6:0] = OPC_JALR; r[14:12] = 3'd0; end
      C_LUI:   r[6:0] = OPC_LUI;
      C_AUIPC: r[6:0] = OPC_AUIPC;
      C_ILL:   r[6:0] = ill_opc[$urandom_range(0, 4)];
      default: ;
    endcase
    return r;
  endfunction
  // Expected per-instruction totals from the zero-wait cycle table plus the wait cycles injected
  function automatic obs_t model(input int cls, input logic [31:0] insn, input int fl, input int dl,
                                 input logic less, input logic eq);
    obs_t e = '{default: 0};
    logic [2:0] f3 = insn[14:12];
    bit mem = (cls == C_LD) || (cls == C_ST);
    bit mto = mem && dl >= TO;
    bit tk;
    int base;
    if (cls == C_FTO) begin
      e.cyc = TO; e.n_imem = TO; e.n_berr = 1;
      return e;
    end
    base = (cls == C_LD) ? 5 : (cls == C_BR) ? 3 : (cls == C_ILL) ? 2 : 4;
    e.cyc    = mto ? 3 + fl + TO : base + fl + (mem ? dl : 0);
    e.n_imem = fl + 1;
    e.n_dmem = !mem ? 0 : mto ? TO : dl + 1;
    e.n_we   = (cls == C_ST) ? e.n_dmem : 0;
    e.n_ill  = int'(cls == C_ILL);
    e.n_berr = int'(mto);
    e.n_ret  = int'(!mto && cls != C_ILL);
    e.n_wen  = int'(e.n_ret == 1 && cls != C_ST && cls != C_BR);
    e.n_pcwe = int'(!mto);
    case (f3)
      3'd0:       tk = eq;
      3'd1:       tk = !eq;
      3'd4, 3'd6: tk = less;
      default:    tk = !less;
    endcase
    e.pc_sel = (cls == C_BR) ? int'(tk) : int'(cls == C_JAL || cls == C_JALR);
    e.wb     = (cls == C_LD) ? 0 : (cls == C_JAL || cls == C_JALR) ? 2 : 1;
    if (cls == C_LUI) e.alu = int'(ALU_COPY_B);
    else if (cls == C_R || cls == C_I)
      case (f3)
        3'd0:    e.alu = int'((cls == C_R && insn[30]) ? ALU_SUB : ALU_ADD);
        3'd1:    e.alu = int'(ALU_SLL);
        3'd2:    e.alu = int'(ALU_SLT);
        3'd3:    e.alu = int'(ALU_SLTU);
        3'd4:    e.alu = int'(ALU_XOR);
        3'd5:    e.alu = int'(insn[30] ? ALU_SRA : ALU_SRL);
        3'd6:    e.alu = int'(ALU_OR);
        default: e.alu = int'(ALU_AND);
      endcase
    else e.alu = int'(ALU_ADD);
    e.a   = int'(cls == C_BR || cls == C_JAL || cls == C_AUIPC);
    e.b   = int'(cls != C_R);
    e.imm = int'((cls == C_ST) ? IMM_S : (cls == C_BR) ? IMM_B : (cls == C_LUI || cls == C_AUIPC) ? IMM_U :
                 (cls == C_JAL) ? IMM_J : IMM_I);
    e.bun = int'(cls == C_BR && f3[2:1] == 2'b11);
    return e;
  endfunction
  task automatic run(input int cls, input logic [31:0] insn, input int fl, input int dl,
                     input logic less, input logic eq);
    obs_t e, o;
    int   ni = 0, nd = 0;
    bit   done = 0;
    e = model(cls, insn, fl, dl, less, eq);
    o = '{default: 0};
    i_br_less  = less;
    i_br_equal = eq;
    while (!done && o.cyc < 64) begin
      @(negedge i_clk);
      i_inst_vld   = o_imem_req && ni == fl;
      i_inst       = i_inst_vld ? insn : $urandom;
      i_dmem_ready = o_dmem_req && nd == dl;
      #1;
      o.cyc++;
      ni += int'(o_imem_req);
      nd += int'(o_dmem_req);
      o.n_imem += int'(o_imem_req);
      o.n_dmem += int'(o_dmem_req);
      o.n_we   += int'(o_dmem_we);
      o.n_wen  += int'(o_reg_wen);
      o.n_pcwe += int'(o_pc_we);
      o.n_ret  += int'(o_insn_vld);
      o.n_ill  += int'(o_illegal);
      o.n_berr += int'(o_bus_err);
      if (o_pc_we) o.pc_sel = int'(o_pc_sel);
      if (o_reg_wen) o.wb = int'(o_wb_sel);
      if (o.cyc == fl + 3) begin
        o.alu = int'(o_alu_op); o.a = int'(o_alu_a_sel); o.b = int'(o_alu_b_sel);
        o.imm = int'(o_imm_sel); o.bun = int'(o_br_un);
      end
      done = o_insn_vld | o_illegal | o_bus_err;
    end
    @(posedge i_clk);
    #1;
    exp_ret += e.n_ret;
    if (cls != C_FTO) last_ir = insn;
    check("cycles", o.cyc, e.cyc);
    check("imem_req_cycles", o.n_imem, e.n_imem);
    check("dmem_req_cycles", o.n_dmem, e.n_dmem);
    check("dmem_we_cycles", o.n_we, e.n_we);
    check("reg_wen_count", o.n_wen, e.n_wen);
    check("pc_we_count", o.n_pcwe, e.n_pcwe);
    check("pc_sel", o.pc_sel, e.pc_sel);
    check("retire_count", o.n_ret, e.n_ret);
    check("illegal_count", o.n_ill, e.n_ill);
    check("bus_err_count", o.n_berr, e.n_berr);
    check("ir", o_ir, last_ir);
    check("instret", o_instret, exp_ret % (1 << CW));
    if (e.n_wen != 0) check("wb_sel", o.wb, e.wb);
    if (cls != C_ILL && cls != C_FTO) begin
      check("alu_op", o.alu, e.alu);
      check("alu_a_sel", o.a, e.a);
      check("alu_b_sel", o.b, e.b);
      check("imm_sel", o.imm, e.imm);
      check("br_un", o.bun, e.bun);
    end
  endtask
  initial begin
    int fls [4] = '{0, 1, 2, TO - 1};
    int dls [5] = '{0, 1, 3, TO - 1, TO};
    int cls;
    i_reset = 1'b0; i_inst = '0; i_inst_vld = 1'b0; i_dmem_ready = 1'b0; i_br_less = 1'b0; i_br_equal = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_strobes", {o_imem_req, o_dmem_req, o_reg_wen, o_pc_we, o_insn_vld, o_illegal, o_bus_err}, 0);
    check("reset_ir", o_ir, 32'h13);
    check("reset_instret", o_instret, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("fetch_after_reset", o_imem_req, 1);
    run(C_R, 32'h002081B3, 0, 0, 1'b0, 1'b0);
    run(C_LD, 32'h0040A283, 0, 2, 1'b0, 1'b0);
    run(C_BR, 32'h0020D463, 0, 0, 1'b0, 1'b0);
    run(C_BR, 32'h0020E463, 1, 0, 1'b1, 1'b0);
    run(C_ST, 32'h0020A023, 0, TO, 1'b0, 1'b0);
    run(C_ILL, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    run(C_FTO, 32'h0, TO, 0, 1'b0, 1'b0);
    run(C_ST, 32'h0020A023, TO - 1, TO - 1, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 10);
      run(cls, build(cls), (cls == C_FTO) ? TO : fls[$urandom_range(0, 3)], dls[$urandom_range(0, 4)],
          1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 10 && !o_dmem_req; k++) begin
      @(negedge i_clk);
      i_inst_vld   = o_imem_req;
      i_inst       = 32'h0040A283;
      i_dmem_ready = 1'b0;
      #1;
    end
    check("reached_mem", o_dmem_req, 1);
    #2 i_reset = 1'b0;
    #1;
    check("midmem_reset_strobes", {o_imem_req, o_dmem_req, o_reg_wen, o_pc_we, o_insn_vld, o_illegal, o_bus_err}, 0);
    check("midmem_reset_ir", o_ir, 32'h13);
    check("midmem_reset_instret", o_instret, 0);
    exp_ret = 0;
    last_ir = 32'h13;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1; i_inst_vld = 1'b0;
    #1;
    check("fetch_after_release", o_imem_req, 1);
    run(C_R, 32'h002081B3, 0, 0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
